mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single shared main memory (multi-cycle, pipelined, returns data_valid a fixed number of cycles after a read) between I-cache and D-cache miss/write traffic.
- Replaces the ad-hoc "icache busy wins" select in cpu.
- Locks ownership for a whole line fill and drains in-flight reads before handing over.
- Routes data_valid and read data only to the owner that issued the reads.

Parameters:
- CNT_W, 3, width of outstanding-read counter; max in flight = 2^CNT_W - 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-cache requests memory (held high for the entire fill)
- i_addr  in  16  I-cache access address
- i_gnt  out  1  access from I-cache issued this cycle
- i_data_valid  out  1  read data valid for I-cache
- d_req  in  1  D-cache requests memory
- d_wr  in  1  D-cache access is a write
- d_addr  in  16  D-cache access address
- d_wdata  in  16  D-cache write data
- d_gnt  out  1  access from D-cache issued this cycle
- d_data_valid  out  1  read data valid for D-cache
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_data_valid  in  1  memory read return strobe
- busy  out  1  state != IDLE
- err  out  1  sticky: data_valid seen with nothing outstanding

Behaviour:
- Reset, synchronous:
  - state=IDLE, owner=I, last_gnt=I, outstanding=0, err=0.
  - All outputs 0; mem_addr and mem_wdata are 0.
- States: IDLE, I_OWN, D_OWN, DRAIN.
- IDLE:
  - Never asserts mem_en.
  - d_req -> D_OWN (owner=D); else i_req -> I_OWN (owner=I).
  - Both requesting -> D wins. The MEM-stage instruction is older.
  - Takes exactly one cycle, so there is one dead cycle between ownerships.
- X_OWN:
  - x_gnt = x_req & (outstanding != max). Counter-full back-pressure drops the grant.
  - mem_en = x_gnt.
  - mem_addr, mem_wr and mem_wdata are combinational pass-through from the owner. mem_wr and mem_wdata are 0 for I.
  - The non-owner's gnt is 0.
  - A requester treats an access as issued only when req & gnt are both high in that cycle.
- Outstanding counter:
  - +1 on issued read (mem_en & ~mem_wr).
  - -1 on mem_data_valid.
  - Both in the same cycle: unchanged.
  - Writes are never counted.
- Leaving X_OWN when x_req = 0:
  - Outstanding (next value) = 0 -> IDLE.
  - Otherwise -> DRAIN, with owner retained.
- DRAIN:
  - mem_en = 0 and both gnts are 0.
  - Moves to IDLE in the cycle after outstanding reaches 0.
  - New requests wait.
- Data return routing:
  - i_data_valid = mem_data_valid & owner==I & outstanding!=0. d_data_valid is the same with owner==D.
  - Valid in IDLE is never routed.
  - Read data bypasses this block (shared bus); only the valids are steered.
- Stray return: mem_data_valid with outstanding==0 -> dropped, err set. err clears only on rst; the counter never underflows.
- Re-request during ownership: req dropping and re-rising in the next cycle while still X_OWN keeps ownership; no re-arbitration.
- Reset mid-fill: all state cleared. Returns from the aborted fill are stray (err=1) unless memory is reset in the same cycle (normal cpu wiring).

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: simultaneous i_req & d_req in IDLE grant the requester opposite to last_gnt. last_gnt updates on every entry to I_OWN or D_OWN.
- Undefined: fixed D-priority as above; last_gnt is unused.

Test Plan:
- I-fill alone: i_req high for 8 issued reads, addrs 0x0010..0x001E, memory latency 4.
  - -> i_gnt 8 cycles after one IDLE cycle; 8 i_data_valid pulses; d_data_valid never.
  - -> state DRAIN for 4 cycles, then IDLE; busy then 0.
- Collision: i_req and d_req rise the same cycle in IDLE.
  - -> d_gnt first; i_gnt only after D drains plus the 1 IDLE cycle.
  - -> With MEM_ARB_RR_EN and last_gnt=D, I wins instead.
- D write during I fill: d_req, d_wr=1, addr 0x8000, wdata 0xBEEF while I_OWN.
  - -> d_gnt stays 0 until I finishes.
  - -> Then single cycle mem_en=1, mem_wr=1, mem_addr=0x8000, mem_wdata=0xBEEF.
  - -> Returns to IDLE next cycle with no DRAIN.
- Back-pressure: CNT_W=2, memory latency 4, i_req held.
  - -> i_gnt high 3 cycles, low until first return, never more than 3 outstanding.
- Stray valid: pulse mem_data_valid in IDLE.
  - -> no x_data_valid; err=1 and remains 1 until rst.
- Reset mid-fill: rst after 3 issued I reads.
  - -> next cycle all outputs 0, state IDLE, outstanding 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter between I-cache and D-cache with ownership lock and read drain.
// Optional round-robin tie-break on simultaneous requests: define MEM_ARB_RR_EN.
module mem_arbiter #(
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  output logic        i_data_valid,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_data_valid,
  output logic        busy,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, I_OWN, D_OWN, DRAIN} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t           state, state_nxt;
  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] outstanding, out_nxt, out_after_ret;
  logic             cnt_full, ret_ok, stray, rd_issue, pick_d;

  assign cnt_full      = (outstanding == CNT_MAX);
  assign ret_ok        = mem_data_valid & (outstanding != '0);
  assign stray         = mem_data_valid & (outstanding == '0);
  assign out_after_ret = outstanding - {{(CNT_W-1){1'b0}}, ret_ok};

`ifdef MEM_ARB_RR_EN
  owner_t last_gnt;
  // On a tie, the side that did not win last time goes first.
  assign pick_d = d_req & (~i_req | (last_gnt == OWN_I));
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = D_OWN;
          owner_nxt = OWN_D;
        end else if (i_req) begin
          state_nxt = I_OWN;
          owner_nxt = OWN_I;
        end
      end
      I_OWN: begin
        i_gnt    = i_req & ~cnt_full;
        mem_en   = i_gnt;
        mem_addr = i_addr;
        // With the request low nothing issues, so only a return can move the count.
        if (!i_req) state_nxt = (out_after_ret == '0) ? IDLE : DRAIN;
      end
      D_OWN: begin
        d_gnt     = d_req & ~cnt_full;
        mem_en    = d_gnt;
        mem_wr    = d_wr;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        if (!d_req) state_nxt = (out_after_ret == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_issue = mem_en & ~mem_wr;

  always_comb begin
    out_nxt = outstanding;
    if (rd_issue && !ret_ok)      out_nxt = outstanding + 1'b1;
    else if (!rd_issue && ret_ok) out_nxt = outstanding - 1'b1;
  end

  assign i_data_valid = ret_ok & (owner == OWN_I);
  assign d_data_valid = ret_ok & (owner == OWN_D);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_I;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      outstanding <= out_nxt;
      if (stray) err <= 1'b1;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)                                    last_gnt <= OWN_I;
    else if (state == IDLE && state_nxt != IDLE) last_gnt <= owner_nxt;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, directed fill sequences,
// and randomized traffic checked against an ownership/outstanding-count reference model.
module tb_mem_arbiter;
  localparam int CNT_W = 3;
  localparam int MAXO  = (1 << CNT_W) - 1;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_req, d_req, d_wr, mem_data_valid;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_data_valid, d_gnt, d_data_valid, mem_en, mem_wr, busy, err;
  logic [15:0] mem_addr, mem_wdata;

  mem_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_data_valid(d_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .busy(busy), .err(err)
  );

  // {i_gnt,d_gnt,mem_en,mem_wr,mem_addr,mem_wdata,i_dv,d_dv,busy,err}
  logic [39:0] act;
  assign act = {i_gnt, d_gnt, mem_en, mem_wr, mem_addr, mem_wdata,
                i_data_valid, d_data_valid, busy, err};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model: who holds memory (-1 nobody, 0 I, 1 D), whether it is draining,
  // how many reads are in flight, and the memory's return schedule.
  int  m_holder, m_out, m_last, cyc, lat;
  bit  m_drain, m_err;
  bit  due[int];
  logic [39:0] smp;

  function automatic logic [39:0] model_exp();
    bit active, req_h, g, wr, idv, ddv;
    logic [15:0] a, wd;
    active = (m_holder >= 0) && !m_drain;
    req_h  = (m_holder == 1) ? d_req : i_req;
    g      = active && req_h && (m_out < MAXO);
    a      = !active ? 16'h0 : (m_holder == 1 ? d_addr : i_addr);
    wr     = active && (m_holder == 1) && d_wr;
    wd     = (active && m_holder == 1) ? d_wdata : 16'h0;
    idv    = mem_data_valid && (m_out > 0) && (m_holder == 0);
    ddv    = mem_data_valid && (m_out > 0) && (m_holder == 1);
    return {g && (m_holder == 0), g && (m_holder == 1), g, wr, a, wd,
            idv, ddv, m_holder >= 0, m_err};
  endfunction

  task automatic model_reset();
    m_holder = -1; m_drain = 1'b0; m_out = 0; m_err = 1'b0; m_last = 0;
  endtask

  task automatic model_step(input logic [39:0] e);
    int nout;
    bit issued_rd;
    if (rst) begin
      model_reset();
      return;
    end
    issued_rd = e[37] && !e[36];
    nout = m_out + (issued_rd ? 1 : 0) - ((mem_data_valid && m_out > 0) ? 1 : 0);
    if (mem_data_valid && m_out == 0) m_err = 1'b1;
    if (m_holder < 0) begin
      if (i_req && d_req)  m_holder = RR ? ((m_last == 1) ? 0 : 1) : 1;
      else if (d_req)      m_holder = 1;
      else if (i_req)      m_holder = 0;
      if (m_holder >= 0) m_last = m_holder;
    end else if (!m_drain) begin
      if (!((m_holder == 1) ? d_req : i_req)) begin
        if (nout == 0) m_holder = -1;
        else           m_drain = 1'b1;
      end
    end else if (m_out == 0) begin
      m_holder = -1;
      m_drain  = 1'b0;
    end
    m_out = nout;
    if (issued_rd) due[cyc + lat] = 1'b1;
  endtask

  task automatic cycle(input bit stray);
    logic [39:0] e;
    mem_data_valid = due.exists(cyc) || stray;
    if (due.exists(cyc)) due.delete(cyc);
    #1;
    e = model_exp();
    smp = act;
    check($sformatf("cyc%0d", cyc), act, e);
    model_step(e);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; mem_data_valid = 1'b0;
  endtask

  task automatic reset_all();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    model_reset();
    due.delete();
    #1;
    check("reset_state", act, 40'h0);
  endtask

  typedef struct {
    logic rst, ireq;
    logic [15:0] iaddr;
    logic dreq, dwr;
    logic [15:0] daddr, wd;
    logic mdv;
    logic [39:0] exp;
  } vec_t;

  function automatic logic [39:0] ex(bit ig, bit dg, bit en, bit wr, logic [15:0] a,
                                     logic [15:0] wd, bit idv, bit ddv, bit b, bit e);
    return {ig, dg, en, wr, a, wd, idv, ddv, b, e};
  endfunction

  function automatic vec_t mk(bit r, bit ir, logic [15:0] ia, bit dr, bit dw,
                              logic [15:0] da, logic [15:0] w, bit mv, logic [39:0] e);
    vec_t v;
    v.rst = r; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwr = dw;
    v.daddr = da; v.wd = w; v.mdv = mv; v.exp = e;
    return v;
  endfunction

  vec_t tbl[17];
  int n, ndv, nddv, tail, first, maxo, bp_gnts;

  initial begin
    cyc = 0; lat = 4;
    idle_inputs();
    rst = 1'b1;
    model_reset();

    // I fill interrupted by a pending D write, then the write, a collision, a stray return.
    tbl[0]  = mk(0,1,16'h0010,0,0,16'h0000,16'h0000,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,0));
    tbl[1]  = mk(0,1,16'h0010,1,1,16'h8000,16'hBEEF,0, ex(1,0,1,0,16'h0010,16'h0000,0,0,1,0));
    tbl[2]  = mk(0,1,16'h0012,1,1,16'h8000,16'hBEEF,0, ex(1,0,1,0,16'h0012,16'h0000,0,0,1,0));
    tbl[3]  = mk(0,0,16'h0000,1,1,16'h8000,16'hBEEF,1, ex(0,0,0,0,16'h0000,16'h0000,1,0,1,0));
    tbl[4]  = mk(0,0,16'h0000,1,1,16'h8000,16'hBEEF,1, ex(0,0,0,0,16'h0000,16'h0000,1,0,1,0));
    tbl[5]  = mk(0,0,16'h0000,1,1,16'h8000,16'hBEEF,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,1,0));
    tbl[6]  = mk(0,0,16'h0000,1,1,16'h8000,16'hBEEF,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,0));
    tbl[7]  = mk(0,0,16'h0000,1,1,16'h8000,16'hBEEF,0, ex(0,1,1,1,16'h8000,16'hBEEF,0,0,1,0));
    tbl[8]  = mk(0,0,16'h0000,0,0,16'h0000,16'h0000,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,1,0));
    tbl[9]  = mk(0,1,16'h0020,1,0,16'h4000,16'h0000,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,0));
    if (RR) begin
      tbl[10] = mk(0,1,16'h0020,1,0,16'h4000,16'h0000,0, ex(1,0,1,0,16'h0020,16'h0000,0,0,1,0));
      tbl[11] = mk(0,0,16'h0000,0,0,16'h0000,16'h0000,1, ex(0,0,0,0,16'h0000,16'h0000,1,0,1,0));
    end else begin
      tbl[10] = mk(0,1,16'h0020,1,0,16'h4000,16'h0000,0, ex(0,1,1,0,16'h4000,16'h0000,0,0,1,0));
      tbl[11] = mk(0,0,16'h0000,0,0,16'h0000,16'h0000,1, ex(0,0,0,0,16'h0000,16'h0000,0,1,1,0));
    end
    tbl[12] = mk(0,0,16'h0000,0,0,16'h0000,16'h0000,1, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,0));
    tbl[13] = mk(0,0,16'h0000,0,0,16'h0000,16'h0000,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,1));
    tbl[14] = mk(0,0,16'h0000,0,0,16'h0000,16'h0000,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,1));
    tbl[15] = mk(1,0,16'h0000,0,0,16'h0000,16'h0000,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,1));
    tbl[16] = mk(0,0,16'h0000,0,0,16'h0000,16'h0000,0, ex(0,0,0,0,16'h0000,16'h0000,0,0,0,0));

    @(posedge clk);
    @(negedge clk);
    reset_all();

    for (int i = 0; i < 17; i++) begin
      rst = tbl[i].rst; i_req = tbl[i].ireq; i_addr = tbl[i].iaddr;
      d_req = tbl[i].dreq; d_wr = tbl[i].dwr; d_addr = tbl[i].daddr;
      d_wdata = tbl[i].wd; mem_data_valid = tbl[i].mdv;
      #1;
      check($sformatf("vec%0d", i), act, tbl[i].exp);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end

    // I line fill of 8 reads, latency 4.
    reset_all();
    lat = 4; n = 0; ndv = 0; nddv = 0; tail = 0; first = -1;
    for (int k = 0; k < 30; k++) begin
      i_req  = (n < 8);
      i_addr = 16'h0010 + 16'(2 * n);
      cycle(1'b0);
      if (smp[39]) begin
        if (first < 0) first = k;
        n++;
      end
      if (smp[3]) ndv++;
      if (smp[2]) nddv++;
      if (!i_req && smp[1]) tail++;
    end
    check_int("fill_first_gnt", first, 1);
    check_int("fill_gnts", n, 8);
    check_int("fill_i_dv", ndv, 8);
    check_int("fill_d_dv", nddv, 0);
    check_int("fill_tail_busy", tail, 5);
    check_int("fill_end_busy", int'(busy), 0);

    // Back-pressure: slow memory fills the counter.
    reset_all();
    lat = 10; maxo = 0; bp_gnts = 0;
    for (int k = 0; k < 40; k++) begin
      i_req = 1'b1;
      i_addr = 16'(k);
      cycle(1'b0);
      if (m_out > maxo) maxo = m_out;
      if (k < 12 && smp[39]) bp_gnts++;
    end
    i_req = 1'b0;
    for (int k = 0; k < 20; k++) cycle(1'b0);
    check_int("bp_max_outstanding", maxo, MAXO);
    check_int("bp_gnts_first12", bp_gnts, MAXO);
    check_int("bp_end_busy", int'(busy), 0);

    // Reset in the middle of a fill; memory is reset alongside.
    reset_all();
    lat = 4; n = 0;
    for (int k = 0; k < 10 && n < 3; k++) begin
      i_req = 1'b1;
      cycle(1'b0);
      if (smp[39]) n++;
    end
    check_int("midrst_gnts", n, 3);
    rst = 1'b1;
    cycle(1'b0);
    due.delete();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("midrst_outputs", act, 40'h0);
    for (int k = 0; k < 8; k++) cycle(1'b0);
    check_int("midrst_err", int'(err), 0);

    // Randomized traffic against the model.
    for (int ph = 0; ph < 6; ph++) begin
      reset_all();
      lat = $urandom_range(1, 10);
      for (int k = 0; k < 250; k++) begin
        if ($urandom_range(0, 7) == 0) i_req = ~i_req;
        if ($urandom_range(0, 7) == 0) d_req = ~d_req;
        d_wr    = $urandom_range(0, 1) == 1;
        i_addr  = 16'($urandom);
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
        rst     = ($urandom_range(0, 199) == 0);
        cycle($urandom_range(0, 63) == 0);
        if (rst) begin
          due.delete();
          rst = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
